cds_pll_lock_ctrl: RTL and testbench

CDS_PLL_LOCK_CTRL -- requirements
Module: cds_pll_lock_ctrl

---
 rtl/cds_pll_ctrl_pkg.sv | 15 +
 rtl/cds_sync2.sv | 25 ++
 rtl/cds_pll_lock_ctrl.sv | 143 ++++++++++++++
 tb/tb_cds_pll_lock_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cds_pll_ctrl_pkg.sv
// rtl/cds_pll_ctrl_pkg.sv - shared state encoding and widths for the PLL lock controller
package cds_pll_ctrl_pkg;

    localparam int STATE_W = 3;
    localparam int CNT_W   = 16;

    typedef enum logic [STATE_W-1:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_READY     = 3'd3,
        ST_FAIL      = 3'd4
    } state_e;

endpackage

// File: rtl/cds_sync2.sv
// rtl/cds_sync2.sv - two-flop synchronizer for a single asynchronous level
module cds_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/cds_pll_lock_ctrl.sv
// rtl/cds_pll_lock_ctrl.sv - PLL reset/lock sequencer with retry and fail handling; optional CDS_PLL_LOSS_CNT_EN adds loss_cnt
module cds_pll_lock_ctrl
    import cds_pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES          = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int MAX_RETRIES         = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               pll_locked,
    output logic               pll_rst,
    output logic               ready,
    output logic               fail,
    output logic [STATE_W-1:0] state,
    output logic [3:0]         retry_cnt
`ifdef CDS_PLL_LOSS_CNT_EN
    ,
    output logic [CNT_W-1:0]   loss_cnt
`endif
);

    // Terminal counts: the counter starts at 0 on state entry, so N cycles end at N-1.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [3:0]       RETRY_LIMIT = 4'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         retry_q, retry_d;
    logic               pll_rst_q, ready_q, fail_q;
    logic               locked_s;

    cds_sync2 u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    // Next-state, retry and shared cycle counter; start overrides every other transition.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        if (start) begin
            state_d = ST_RESET;
            retry_d = 4'd0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    if (cnt_q == RST_LAST) state_d = ST_WAIT_LOCK;
                end
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = ST_STABLE;
                    end else if (cnt_q == TMO_LAST) begin
                        retry_d = retry_q + 4'd1;
                        state_d = ((retry_q + 4'd1) == RETRY_LIMIT) ? ST_FAIL : ST_RESET;
                    end
                end
                ST_STABLE: begin
                    if (!locked_s) begin
                        state_d = ST_WAIT_LOCK;
                    end else if (cnt_q == STABLE_LAST) begin
                        state_d = ST_READY;
                        retry_d = 4'd0;
                    end
                end
                ST_READY: begin
                    if (!locked_s) begin
                        state_d = ST_RESET;
                        retry_d = 4'd0;
                    end
                end
                ST_FAIL: begin
                    state_d = ST_FAIL;
                end
                default: begin
                    state_d = ST_RESET;
                end
            endcase
        end
        // A repeated start in RESET also reloads the counter, so the pulse is timed from the last start.
        if (start || (state_d != state_q)) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // State, counter and outputs; outputs are decoded from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            cnt_q     <= '0;
            retry_q   <= 4'd0;
            pll_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            pll_rst_q <= (state_d == ST_RESET) || (state_d == ST_FAIL);
            ready_q   <= (state_d == ST_READY);
            fail_q    <= (state_d == ST_FAIL);
        end
    end

`ifdef CDS_PLL_LOSS_CNT_EN
    logic [CNT_W-1:0] loss_q;
    logic             loss_event;

    // A loss is a READY-to-RESET drop caused by the lock going away, not by start.
    always_comb begin
        loss_event = (state_q == ST_READY) && !start && !locked_s;
    end

    // Saturating loss counter, cleared only by rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_q <= '0;
        end else if (loss_event && (loss_q != CNT_MAX)) begin
            loss_q <= loss_q + 1'b1;
        end
    end

    assign loss_cnt = loss_q;
`endif

    assign pll_rst   = pll_rst_q;
    assign ready     = ready_q;
    assign fail      = fail_q;
    assign state     = state_q;
    assign retry_cnt = retry_q;

endmodule

// File: tb/tb_cds_pll_lock_ctrl.sv
// tb/tb_cds_pll_lock_ctrl.sv - self-checking bench for cds_pll_lock_ctrl against a behavioural model
module tb_cds_pll_lock_ctrl;

    localparam int RST_N_CYC = 4;
    localparam int STB_N_CYC = 8;
    localparam int TMO_N_CYC = 20;
    localparam int MAX_RT    = 2;

    localparam int PH_RESET = 0;
    localparam int PH_WAIT  = 1;
    localparam int PH_STAB  = 2;
    localparam int PH_READY = 3;
    localparam int PH_FAIL  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pll_locked = 1'b1;
    logic        pll_rst;
    logic        ready;
    logic        fail;
    logic [2:0]  state;
    logic [3:0]  retry_cnt;
`ifdef CDS_PLL_LOSS_CNT_EN
    logic [15:0] loss_cnt;
`endif

    int checks = 0;
    int passes = 0;

    cds_pll_lock_ctrl #(
        .RST_CYCLES          (RST_N_CYC),
        .LOCK_STABLE_CYCLES  (STB_N_CYC),
        .LOCK_TIMEOUT_CYCLES (TMO_N_CYC),
        .MAX_RETRIES         (MAX_RT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .pll_locked (pll_locked),
        .pll_rst    (pll_rst),
        .ready      (ready),
        .fail       (fail),
        .state      (state),
        .retry_cnt  (retry_cnt)
`ifdef CDS_PLL_LOSS_CNT_EN
        ,
        .loss_cnt   (loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural model: phase, time spent in phase, failed attempts, loss events,
    // and a two-deep history of pll_locked standing in for the synchronizer.
    int m_phase = PH_RESET;
    int m_time  = 0;
    int m_tries = 0;
    int m_loss  = 0;
    bit m_hist[2] = '{1'b0, 1'b0};

    always @(posedge clk or negedge rst_n) begin : model
        bit seen;
        if (!rst_n) begin
            m_phase = PH_RESET;
            m_time  = 0;
            m_tries = 0;
            m_loss  = 0;
            m_hist  = '{1'b0, 1'b0};
        end else begin
            seen      = m_hist[1];
            m_hist[1] = m_hist[0];
            m_hist[0] = pll_locked;
            m_time    = m_time + 1;
            if (start) begin
                m_phase = PH_RESET; m_time = 0; m_tries = 0;
            end else if (m_phase == PH_RESET && m_time == RST_N_CYC) begin
                m_phase = PH_WAIT; m_time = 0;
            end else if (m_phase == PH_WAIT && seen) begin
                m_phase = PH_STAB; m_time = 0;
            end else if (m_phase == PH_WAIT && m_time == TMO_N_CYC) begin
                m_tries = m_tries + 1;
                m_phase = (m_tries == MAX_RT) ? PH_FAIL : PH_RESET;
                m_time  = 0;
            end else if (m_phase == PH_STAB && !seen) begin
                m_phase = PH_WAIT; m_time = 0;
            end else if (m_phase == PH_STAB && m_time == STB_N_CYC) begin
                m_phase = PH_READY; m_time = 0; m_tries = 0;
            end else if (m_phase == PH_READY && !seen) begin
                m_phase = PH_RESET; m_time = 0; m_tries = 0;
                if (m_loss < 65535) m_loss = m_loss + 1;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Per-cycle comparison of every output against the model, away from the active edge.
    always @(negedge clk) begin : compare
        int exp_v;
        int act_v;
        exp_v = (m_phase << 8) | (m_tries << 4)
              | (((m_phase == PH_RESET) || (m_phase == PH_FAIL)) ? 4 : 0)
              | ((m_phase == PH_READY) ? 2 : 0)
              | ((m_phase == PH_FAIL) ? 1 : 0);
        act_v = (int'(state) << 8) | (int'(retry_cnt) << 4)
              | (pll_rst ? 4 : 0) | (ready ? 2 : 0) | (fail ? 1 : 0);
        chk("model_outputs", act_v, exp_v);
`ifdef CDS_PLL_LOSS_CNT_EN
        chk("model_loss_cnt", int'(loss_cnt), m_loss);
`endif
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int run;
        bit lvl;

        // Power-up with lock already present.
        cyc(3);
        chk("reset_state", int'(state), 0);
        chk("reset_pll_rst", int'(pll_rst), 1);
        rst_n = 1'b1;
        cyc(3);
        chk("rst_pulse_still_high", int'(pll_rst), 1);
        cyc(1);
        chk("rst_pulse_ends", int'(pll_rst), 0);
        chk("enter_wait_lock", int'(state), 1);
        cyc(1);
        chk("enter_stable", int'(state), 2);
        cyc(7);
        chk("not_ready_yet", int'(ready), 0);
        cyc(1);
        chk("ready_rises", int'(ready), 1);
        chk("state_ready", int'(state), 3);

        // Loss of lock in READY.
        pll_locked = 1'b0;
        cyc(2);
        chk("ready_before_sync", int'(ready), 1);
        cyc(1);
        chk("ready_drops", int'(ready), 0);
        chk("loss_to_reset", int'(state), 0);
`ifdef CDS_PLL_LOSS_CNT_EN
        chk("loss_cnt_one", int'(loss_cnt), 1);
`endif

        // Two timeouts lead to FAIL.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(23);
        chk("before_timeout", int'(retry_cnt), 0);
        cyc(1);
        chk("first_timeout_retry", int'(retry_cnt), 1);
        chk("first_timeout_state", int'(state), 0);
        cyc(24);
        chk("fail_state", int'(state), 4);
        chk("fail_flag", int'(fail), 1);
        chk("fail_pll_rst", int'(pll_rst), 1);
        cyc(5);
        chk("fail_sticky", int'(fail), 1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("start_clears_fail", int'(fail), 0);
        chk("start_clears_retry", int'(retry_cnt), 0);

        // start on the same edge as the timeout wins.
        cyc(23);
        chk("wait_before_collide", int'(state), 1);
        start = 1'b1; cyc(1); start = 1'b0;
        chk("collide_state", int'(state), 0);
        chk("collide_retry", int'(retry_cnt), 0);

        // Three-cycle lock glitch during STABLE.
        pll_locked = 1'b1;
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(5);
        chk("glitch_in_stable", int'(state), 2);
        cyc(2);
        pll_locked = 1'b0;
        cyc(3);
        chk("glitch_back_to_wait", int'(state), 1);
        pll_locked = 1'b1;
        cyc(3);
        chk("glitch_restable", int'(state), 2);
        cyc(7);
        chk("glitch_not_ready", int'(ready), 0);
        cyc(1);
        chk("glitch_ready", int'(ready), 1);

        // Asynchronous reset mid-STABLE.
        start = 1'b1; cyc(1); start = 1'b0;
        cyc(6);
        chk("pre_async_stable", int'(state), 2);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_state", int'(state), 0);
        chk("async_pll_rst", int'(pll_rst), 1);
        chk("async_ready", int'(ready), 0);
        chk("async_fail", int'(fail), 0);
        chk("async_retry", int'(retry_cnt), 0);
        cyc(2);
        rst_n = 1'b1;

        // Randomised lock behaviour with occasional start and reset.
        lvl = 1'b1;
        run = 30;
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            if (run == 0) begin
                lvl = ~lvl;
                run = lvl ? $urandom_range(1, 40) : $urandom_range(1, 55);
            end
            run = run - 1;
            pll_locked = lvl;
            start = ($urandom_range(0, 149) == 0);
            rst_n = !($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        #1;
        start = 1'b0;
        rst_n = 1'b1;
        cyc(2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
